// File: rtl/time_update_seq_if.sv
// time_update_seq_if: request, datapath-strobe and status bundle
// for the time/date update sequencer.
interface time_update_seq_if #(
    parameter int FSW = 3
);
    logic           tick;
    logic           set_req;
    logic [FSW-1:0] set_field;
    logic           wrap;
    logic [FSW-1:0] fld_sel;
    logic           La;
    logic           Lb;
    logic           Kc;
    logic           Ea;
    logic           Lr;
    logic           Er;
    logic [1:0]     s;
    logic           busy;
    logic           done;
    logic           set_ack;
    logic           tick_lost;

    modport master (
        input  tick, set_req, set_field, wrap,
        output fld_sel, La, Lb, Kc, Ea, Lr, Er, s,
        output busy, done, set_ack, tick_lost
    );

    modport slave (
        output tick, set_req, set_field, wrap,
        input  fld_sel, La, Lb, Kc, Ea, Lr, Er, s,
        input  busy, done, set_ack, tick_lost
    );
endinterface

// File: rtl/time_update_seq.sv
// time_update_seq: sequencer for the shared time/date incrementer.
// Define SET_CARRY_EN to let user set increments ripple carries.
module time_update_seq #(
    parameter int                    NUM_FIELDS = 6,
    parameter int                    FSW        = 3,
    parameter logic [NUM_FIELDS-1:0] CARRY_MASK = 6'b011111
) (
    input  logic              clk,
    input  logic              rst_n,
    time_update_seq_if.master bus
);
    localparam logic [FSW-1:0] LAST = FSW'(NUM_FIELDS - 1);
    localparam logic [FSW:0]   NF   = (FSW + 1)'(NUM_FIELDS);
`ifdef SET_CARRY_EN
    localparam logic SET_CARRY = 1'b1;
`else
    localparam logic SET_CARRY = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        CMP  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic {
        M_TICK = 1'b0,
        M_SET  = 1'b1
    } mode_t;

    state_t         state_q, state_d;
    mode_t          mode_q, mode_d;
    logic [FSW-1:0] fld_sel_q, fld_sel_d;
    logic           wrap_q, wrap_d;
    logic           tick_pend_q, tick_pend_d;
    logic           tick_lost_q, tick_lost_d;
    logic           la_q, la_d, lb_q, lb_d, kc_q, kc_d;
    logic           ea_q, ea_d, lr_q, lr_d, er_q, er_d;
    logic [1:0]     s_q, s_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           set_ack_c;
    logic           tick_hit;
    logic           carry_ok;

    assign tick_hit = bus.tick | tick_pend_q;
    assign carry_ok = (mode_q == M_TICK) | SET_CARRY;

    // Next state, tick bookkeeping and Moore decode of the next outputs
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fld_sel_d   = fld_sel_q;
        wrap_d      = wrap_q;
        tick_pend_d = tick_pend_q;
        tick_lost_d = tick_lost_q;
        set_ack_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick_hit) begin
                    state_d     = LDA;
                    fld_sel_d   = '0;
                    mode_d      = M_TICK;
                    tick_pend_d = bus.tick & tick_pend_q;
                end else if (bus.set_req) begin
                    set_ack_c = 1'b1;
                    fld_sel_d = bus.set_field;
                    mode_d    = M_SET;
                    state_d   = ({1'b0, bus.set_field} < NF) ? LDA : DONE;
                end
            end
            LDA: state_d = LDB;
            LDB: state_d = CMP;
            CMP: begin
                wrap_d  = bus.wrap;
                state_d = WR;
            end
            WR: begin
                if (wrap_q && carry_ok && (fld_sel_q < LAST)
                    && CARRY_MASK[fld_sel_q]) begin
                    fld_sel_d = fld_sel_q + 1'b1;
                    state_d   = LDA;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (tick_hit) begin
                    state_d     = LDA;
                    fld_sel_d   = '0;
                    mode_d      = M_TICK;
                    tick_pend_d = bus.tick & tick_pend_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.tick && (state_q inside {LDA, LDB, CMP, WR})) begin
            tick_pend_d = 1'b1;
            if (tick_pend_q) tick_lost_d = 1'b1;
        end
        la_d   = (state_d == LDA);
        lb_d   = (state_d == LDB);
        kc_d   = (state_d == LDB);
        ea_d   = (state_d == WR);
        lr_d   = (state_d == WR);
        er_d   = (state_d == WR);
        s_d    = ((state_d == WR) && wrap_d) ? 2'b01 : 2'b00;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= M_TICK;
            fld_sel_q   <= '0;
            wrap_q      <= 1'b0;
            tick_pend_q <= 1'b0;
            tick_lost_q <= 1'b0;
            la_q        <= 1'b0;
            lb_q        <= 1'b0;
            kc_q        <= 1'b0;
            ea_q        <= 1'b0;
            lr_q        <= 1'b0;
            er_q        <= 1'b0;
            s_q         <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fld_sel_q   <= fld_sel_d;
            wrap_q      <= wrap_d;
            tick_pend_q <= tick_pend_d;
            tick_lost_q <= tick_lost_d;
            la_q        <= la_d;
            lb_q        <= lb_d;
            kc_q        <= kc_d;
            ea_q        <= ea_d;
            lr_q        <= lr_d;
            er_q        <= er_d;
            s_q         <= s_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.fld_sel   = fld_sel_q;
    assign bus.La        = la_q;
    assign bus.Lb        = lb_q;
    assign bus.Kc        = kc_q;
    assign bus.Ea        = ea_q;
    assign bus.Lr        = lr_q;
    assign bus.Er        = er_q;
    assign bus.s         = s_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.set_ack   = set_ack_c;
    assign bus.tick_lost = tick_lost_q;
endmodule
